// File: rtl/gb_pkg.sv
// Shared types, widths and image defaults for the Gaussian-blur stage scheduler.
package gb_pkg;

    typedef enum logic [1:0] {
        ST_IN  = 2'd0,
        ST_L1  = 2'd1,
        ST_L2  = 2'd2,
        ST_OUT = 2'd3
    } stage_e;

    localparam int IMG_W_DEF = 488;
    localparam int IMG_H_DEF = 648;
    localparam int WIN_DEF   = 9;

    localparam int X_W     = 9;
    localparam int Y_W     = 10;
    localparam int CNT_W   = 2;
    localparam int OUT_W   = 19;

    // Number of stencils (and therefore OUT transfers) in one frame.
    function automatic int nout(input int img_w, input int img_h, input int win);
        return (img_w - win + 1) * (img_h - win + 1);
    endfunction

endpackage

// File: rtl/gb_rr_arb4.sv
// Four-way round-robin arbiter: grants the first request at or above ptr, wrapping mod 4.
module gb_rr_arb4 (
    input  logic [3:0] req,
    input  logic       en,
    input  logic [1:0] ptr,
    output logic [3:0] gnt
);

    logic       found;
    logic [1:0] idx;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_stage_sched.sv
// Single-issue round-robin scheduler for the IN/LB1D/LB2D/OUT blur stages,
// tracking stream occupancies, LB2D coordinates and frame completion.
module gb_stage_sched
    import gb_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int WIN    = WIN_DEF,
    parameter int FIFO_D = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             arg_1_TVALID,
    output logic             arg_1_TREADY,
    input  logic             arg_0_TREADY,
    output logic             arg_0_TVALID,
    output logic [3:0]       grant,
    output logic             stencil_push,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] slice_cnt,
    output logic [CNT_W-1:0] stencil_cnt,
    output logic             in_full,
    output logic             in_empty,
    output logic             slice_full,
    output logic             slice_empty,
    output logic             stencil_full,
    output logic             stencil_empty,
    output logic [X_W-1:0]   proc_x,
    output logic [Y_W-1:0]   proc_y,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_D);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(IMG_W - 1);
    localparam logic [X_W-1:0]   X_WARM    = X_W'(WIN - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(IMG_H - 1);
    localparam logic [Y_W-1:0]   Y_WARM    = Y_W'(WIN - 1);
    localparam logic [OUT_W-1:0] NOUT_LAST = OUT_W'(nout(IMG_W, IMG_H, WIN) - 1);

    logic [1:0]       ptr;
    logic [OUT_W-1:0] out_cnt;
    logic [3:0]       req;
    stage_e           gnt_stage;

    assign req[ST_IN]  = arg_1_TVALID && (in_cnt < DEPTH);
    assign req[ST_L1]  = (in_cnt != '0) && (slice_cnt < DEPTH);
    assign req[ST_L2]  = (slice_cnt != '0) && (stencil_cnt < DEPTH);
    assign req[ST_OUT] = (stencil_cnt != '0) && arg_0_TREADY;

    gb_rr_arb4 u_arb (
        .req (req),
        .en  (step),
        .ptr (ptr),
        .gnt (grant)
    );

    always_comb begin
        gnt_stage = ST_IN;
        if (grant[ST_L1])  gnt_stage = ST_L1;
        if (grant[ST_L2])  gnt_stage = ST_L2;
        if (grant[ST_OUT]) gnt_stage = ST_OUT;
    end

    // Border windows are consumed but produce no stencil until the window is fully populated.
    assign stencil_push = grant[ST_L2] && (proc_x >= X_WARM) && (proc_y >= Y_WARM);

    assign arg_1_TREADY  = grant[ST_IN];
    assign arg_0_TVALID  = (stencil_cnt != '0);
    assign in_full       = (in_cnt == DEPTH);
    assign in_empty      = (in_cnt == '0);
    assign slice_full    = (slice_cnt == DEPTH);
    assign slice_empty   = (slice_cnt == '0);
    assign stencil_full  = (stencil_cnt == DEPTH);
    assign stencil_empty = (stencil_cnt == '0);
    assign busy          = (in_cnt != '0) || (slice_cnt != '0) || (stencil_cnt != '0)
                        || (proc_x != '0) || (proc_y != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            in_cnt      <= '0;
            slice_cnt   <= '0;
            stencil_cnt <= '0;
            proc_x      <= '0;
            proc_y      <= '0;
            out_cnt     <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (grant != '0) ptr <= 2'(gnt_stage) + 2'd1;

            // Exactly one stage moves per cycle, so no counter is pushed and popped together.
            if (grant[ST_IN]) in_cnt <= in_cnt + 1'b1;

            if (grant[ST_L1]) begin
                in_cnt    <= in_cnt - 1'b1;
                slice_cnt <= slice_cnt + 1'b1;
            end

            if (grant[ST_L2]) begin
                slice_cnt <= slice_cnt - 1'b1;
                if (stencil_push) stencil_cnt <= stencil_cnt + 1'b1;
                if (proc_x == X_LAST) begin
                    proc_x <= '0;
                    proc_y <= (proc_y == Y_LAST) ? '0 : proc_y + 1'b1;
                end else begin
                    proc_x <= proc_x + 1'b1;
                end
            end

            if (grant[ST_OUT]) begin
                stencil_cnt <= stencil_cnt - 1'b1;
                if (out_cnt == NOUT_LAST) begin
                    out_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gb_stage_sched.sv
// Randomized self-checking bench for gb_stage_sched against a queue-occupancy / pixel-index model.
module tb_gb_stage_sched;

    localparam int W    = 12;
    localparam int H    = 10;
    localparam int WN   = 3;
    localparam int D    = 2;
    localparam int NOUT = (W - WN + 1) * (H - WN + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic        arg_1_TVALID = 1'b0;
    logic        arg_1_TREADY;
    logic        arg_0_TREADY = 1'b0;
    logic        arg_0_TVALID;
    logic [3:0]  grant;
    logic        stencil_push;
    logic [1:0]  in_cnt, slice_cnt, stencil_cnt;
    logic        in_full, in_empty, slice_full, slice_empty, stencil_full, stencil_empty;
    logic [8:0]  proc_x;
    logic [9:0]  proc_y;
    logic        frame_done;
    logic        busy;

    gb_stage_sched #(.IMG_W(W), .IMG_H(H), .WIN(WN), .FIFO_D(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .step          (step),
        .arg_1_TVALID  (arg_1_TVALID),
        .arg_1_TREADY  (arg_1_TREADY),
        .arg_0_TREADY  (arg_0_TREADY),
        .arg_0_TVALID  (arg_0_TVALID),
        .grant         (grant),
        .stencil_push  (stencil_push),
        .in_cnt        (in_cnt),
        .slice_cnt     (slice_cnt),
        .stencil_cnt   (stencil_cnt),
        .in_full       (in_full),
        .in_empty      (in_empty),
        .slice_full    (slice_full),
        .slice_empty   (slice_empty),
        .stencil_full  (stencil_full),
        .stencil_empty (stencil_empty),
        .proc_x        (proc_x),
        .proc_y        (proc_y),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            assert (in_cnt <= 2'(D) && slice_cnt <= 2'(D) && stencil_cnt <= 2'(D))
            else $error("FIFO occupancy out of range");
        end
    end

    // Reference model: stream occupancies, LB2D linear pixel index within the frame, OUT count.
    int m_in, m_sl, m_st, m_ptr, m_l2, m_out;
    bit m_fd;
    int fed, outs, l2_grants, first_push, fd_pulses;

    task automatic model_reset();
        m_in = 0; m_sl = 0; m_st = 0; m_ptr = 0; m_l2 = 0; m_out = 0; m_fd = 0;
        fed = 0; outs = 0; l2_grants = 0; first_push = -1; fd_pulses = 0;
    endtask

    task automatic cycle(input logic s, input logic v, input logic r);
        int  k, j, x, y;
        bit  el[4];
        bit  push;
        logic [3:0] exp_grant;
        step = s; arg_1_TVALID = v; arg_0_TREADY = r;
        @(negedge clk);
        el[0] = v && (m_in < D);
        el[1] = (m_in > 0) && (m_sl < D);
        el[2] = (m_sl > 0) && (m_st < D);
        el[3] = (m_st > 0) && r;
        k = -1;
        if (s) begin
            for (int i = 0; i < 4; i++) begin
                j = (m_ptr + i) % 4;
                if (k < 0 && el[j]) k = j;
            end
        end
        exp_grant = (k >= 0) ? (4'b0001 << k) : 4'b0000;
        x = m_l2 % W;
        y = m_l2 / W;
        push = (k == 2) && (x >= WN - 1) && (y >= WN - 1);
        if (frame_done) fd_pulses++;

        check("grant", 32'(grant), 32'(exp_grant));
        check("arg_1_TREADY", 32'(arg_1_TREADY), 32'(exp_grant[0]));
        check("stencil_push", 32'(stencil_push), 32'(push));
        check("in_cnt", 32'(in_cnt), m_in);
        check("slice_cnt", 32'(slice_cnt), m_sl);
        check("stencil_cnt", 32'(stencil_cnt), m_st);
        check("flags", 32'({in_full, in_empty, slice_full, slice_empty, stencil_full, stencil_empty}),
              32'({m_in == D, m_in == 0, m_sl == D, m_sl == 0, m_st == D, m_st == 0}));
        check("arg_0_TVALID", 32'(arg_0_TVALID), 32'(m_st > 0));
        check("proc_x", 32'(proc_x), x);
        check("proc_y", 32'(proc_y), y);
        check("ptr", 32'(dut.ptr), m_ptr);
        check("out_cnt", 32'(dut.out_cnt), m_out);
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("busy", 32'(busy), 32'(m_in > 0 || m_sl > 0 || m_st > 0 || m_l2 != 0));

        @(posedge clk);
        m_fd = 0;
        case (k)
            0: begin m_in++; fed++; end
            1: begin m_in--; m_sl++; end
            2: begin
                m_sl--;
                l2_grants++;
                if (push) begin
                    m_st++;
                    if (first_push < 0) first_push = l2_grants;
                end
                m_l2 = (m_l2 + 1) % (W * H);
            end
            3: begin
                m_st--;
                outs++;
                m_out++;
                if (m_out == NOUT) begin m_out = 0; m_fd = 1; end
            end
            default: ;
        endcase
        if (k >= 0) m_ptr = (k + 1) % 4;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 1'b1; arg_1_TVALID = 1'b1; arg_0_TREADY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; step = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_counts", 32'({in_cnt, slice_cnt, stencil_cnt}), 32'd0);
        check("rst_flags", 32'({in_full, in_empty, slice_full, slice_empty, stencil_full, stencil_empty}),
              32'b010101);
        check("rst_tvalid", 32'(arg_0_TVALID), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ptr", 32'(dut.ptr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fill with a stalled sink: everything saturates and OUT never fires.
        for (int c = 0; c < 200; c++) cycle(1'b1, 1'b1, 1'b0);
        check("sat_in", 32'(in_cnt), 32'd2);
        check("sat_slice", 32'(slice_cnt), 32'd2);
        check("sat_stencil", 32'(stencil_cnt), 32'd2);
        check("sat_no_out", 32'(outs), 32'd0);

        // Free-flowing traffic with a single step bubble.
        for (int c = 0; c < 40; c++) cycle(c != 20, 1'b1, 1'b1);

        // Step held low: nothing moves.
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, 1'b1);

        for (int c = 0; c < 1500; c++)
            cycle(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0);

        // Reset in the middle of traffic discards all state.
        do_reset();

        // One complete frame: exactly W*H pixels, free-running sink.
        for (int c = 0; c < 3000 && fd_pulses == 0; c++)
            cycle(1'b1, fed < W * H, 1'b1);
        check("frame_done_seen", 32'(fd_pulses > 0), 32'd1);
        check("frame_outs_at_done", 32'(outs), NOUT);
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 1'b1);
        check("frame_done_once", 32'(fd_pulses), 32'd1);
        check("frame_outs", 32'(outs), NOUT);
        check("first_push_l2", 32'(first_push), (WN - 1) * W + (WN - 1) + 1);
        check("end_out_cnt", 32'(dut.out_cnt), 32'd0);
        check("end_proc_x", 32'(proc_x), 32'd0);
        check("end_proc_y", 32'(proc_y), 32'd0);
        check("end_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gb_stage_sched.md
Name: gb_stage_sched

Overview:
- Single-issue scheduler for the Gaussian-blur streaming pipeline.
- Four stage instructions:
  - IN: accept on arg_1 into in_stream.
  - L1: LB1D moves a pixel from in_stream into slice_stream.
  - L2: LB2D moves a slice from slice_stream into stencil_stream.
  - OUT: compute from stencil_stream and emit on arg_0.
- Each enabled cycle, grants at most one eligible stage, round-robin. Tracks the 2-entry FIFO occupancies and LB2D image coordinates, and flags frame completion.

Parameters:
- IMG_W, 488, image width in pixels (proc_x range 0..IMG_W-1, must be <=512).
- IMG_H, 648, image height in rows (proc_y range 0..IMG_H-1, must be <=1024).
- WIN, 9, stencil window edge; stencils are produced once proc_x and proc_y are both >= WIN-1.
- FIFO_D, 2, depth of in/slice/stencil streams.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- step  in  1  enable; no grant and no state change when 0
- arg_1_TVALID  in  1  upstream pixel valid
- arg_1_TREADY  out  1  combinational, equals grant[0]
- arg_0_TREADY  in  1  downstream ready
- arg_0_TVALID  out  1  stencil_cnt != 0
- grant  out  4  one-hot or zero: [0]=IN, [1]=L1, [2]=L2, [3]=OUT; combinational
- stencil_push  out  1  combinational; high when grant[2] and the coordinate condition holds
- in_cnt, slice_cnt, stencil_cnt  out  2 each  FIFO occupancies 0..FIFO_D
- in_full, in_empty, slice_full, slice_empty, stencil_full, stencil_empty  out  1 each  decoded from counts
- proc_x  out  9  LB2D column
- proc_y  out  10  LB2D row
- frame_done  out  1  one-cycle registered pulse
- busy  out  1  any count nonzero, or proc_x/proc_y nonzero

Behaviour:
- Reset:
  - All counts, proc_x, proc_y, the round-robin pointer ptr and out_cnt go to 0; frame_done goes to 0.
  - Hence empties=1, fulls=0, arg_0_TVALID=0, busy=0.
  - Reset overrides step; reset mid-frame discards all FIFO state.
- Eligibility, evaluated combinationally from registered state and inputs:
  - IN: arg_1_TVALID & in_cnt<FIFO_D.
  - L1: in_cnt>0 & slice_cnt<FIFO_D.
  - L2: slice_cnt>0 & stencil_cnt<FIFO_D.
  - OUT: stencil_cnt>0 & arg_0_TREADY.
- Arbitration:
  - If step=1, grant the first eligible stage searching from ptr upward, mod 4.
  - On a grant to k, ptr <= (k+1) mod 4. With no grant, ptr is held.
  - grant is all-zero when step=0 or nothing is eligible.
- Updates on the clock edge, with exactly one grant per cycle, so no counter ever sees simultaneous push and pop:
  - IN: in_cnt+1.
  - L1: in_cnt-1, slice_cnt+1.
  - L2: slice_cnt-1; stencil_cnt+1 only if stencil_push.
  - OUT: stencil_cnt-1; out_cnt+1.
- Coordinates:
  - stencil_push = grant[2] & proc_x>=WIN-1 & proc_y>=WIN-1, using pre-increment values.
  - On each L2 grant: if proc_x==IMG_W-1 then proc_x <= 0 and proc_y increments (wrapping to 0 at IMG_H-1); else proc_x+1.
- Frame completion:
  - out_cnt is 19 bits and counts to NOUT = (IMG_W-WIN+1)*(IMG_H-WIN+1).
  - On the OUT grant that makes out_cnt reach NOUT: out_cnt <= 0 and frame_done=1 on the next cycle.
- Never grant pop from empty or push to full. A bench assertion must flag any count leaving 0..FIFO_D.

Decomposition:
- Package gb_pkg holds:
  - the stage enum (ST_IN=0, ST_L1=1, ST_L2=2, ST_OUT=3);
  - the IMG_W, IMG_H and WIN defaults;
  - the NOUT function;
  - widths for proc_x (9), proc_y (10) and FIFO counts (2).
- One sub-module, gb_rr_arb4: a 4-way round-robin arbiter with inputs req[3:0], en and ptr, and output one-hot gnt. ptr update stays in the parent.

Test Plan:
- Reset check: assert rst for 2 cycles mid-traffic -> all counts 0, all empties 1, arg_0_TVALID 0, grant 0, ptr 0.
- Fill/backpressure: arg_1_TVALID=1, arg_0_TREADY=0, step=1 -> in_cnt saturates at 2 and arg_1_TREADY is never asserted while in_full=1. Slice and stencil counts reach 2 and then stall; no OUT grant.
- Round-robin fairness: all four stages kept eligible -> grant sequence 0001, 0010, 0100, 1000 repeating; with step toggled to 0 for one cycle, grant=0 and ptr is held.
- Warm-up gating (IMG_W=12, IMG_H=10, WIN=3): first stencil_push on the L2 grant with proc_x=2, proc_y=2. That is the 27th L2 grant, after 26 prior non-pushing grants. Then proc_x wraps 11->0 with proc_y incrementing.
- Frame completion, same small params with steady traffic: exactly 80 OUT grants (10*8), frame_done pulses once, one cycle after the 80th. out_cnt, proc_x and proc_y all return to 0.
- Step-gating: step=0 for 5 cycles with eligible stages -> all registers unchanged, arg_1_TREADY=0.
